// File: rtl/trafficgenr_axil_slave.sv
// trafficgenr_axil_slave: AXI4-Lite S00_AXI register slave for the trafficgenr IP.
// Holds four 32-bit control registers (exported on slv_regs). AW and W are
// accepted independently and in any order; one write and one read may be outstanding.
// Optional build macro: TRAFFICGENR_WSTRB_EN -- when defined, WSTRB selects which
// bytes a write updates; when undefined, every committed write replaces all 32 bits.
module trafficgenr_axil_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                              ACLK,
   input  logic                              ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     AWADDR,
   input  logic [2:0]                        AWPROT,
   input  logic                              AWVALID,
   output logic                              AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   WSTRB,
   input  logic                              WVALID,
   output logic                              WREADY,
   output logic [1:0]                        BRESP,
   output logic                              BVALID,
   input  logic                              BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     ARADDR,
   input  logic [2:0]                        ARPROT,
   input  logic                              ARVALID,
   output logic                              ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     RDATA,
   output logic [1:0]                        RRESP,
   output logic                              RVALID,
   input  logic                              RREADY,
   output logic [4*C_S_AXI_DATA_WIDTH-1:0]   slv_regs
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int SW = C_S_AXI_DATA_WIDTH / 8;

   logic [DW-1:0] reg_file [4];

   // Write-side holding state: a channel that handshakes early waits here for its partner.
   logic          aw_held;
   logic          w_held;
   logic [1:0]    awaddr_q;
   logic [DW-1:0] wdata_q;
   logic [SW-1:0] wstrb_q;

   logic          aw_hs;
   logic          w_hs;
   logic          ar_hs;
   logic          commit;
   logic [1:0]    wr_idx;
   logic [DW-1:0] wr_data;
   logic [SW-1:0] wr_strb;
   logic [DW-1:0] wr_merged;

   // Readiness depends on registered state only, so no combinational path from VALID to READY.
   assign AWREADY = !aw_held && !BVALID;
   assign WREADY  = !w_held && !BVALID;
   assign ARREADY = !RVALID;
   assign BRESP   = 2'b00;
   assign RRESP   = 2'b00;

   assign aw_hs = AWVALID && AWREADY;
   assign w_hs  = WVALID && WREADY;
   assign ar_hs = ARVALID && ARREADY;

   // A write commits once both halves are present, taking whichever is arriving this cycle.
   assign commit  = (aw_held || aw_hs) && (w_held || w_hs) && !BVALID;
   assign wr_idx  = aw_hs ? AWADDR[3:2] : awaddr_q;
   assign wr_data = w_hs ? WDATA : wdata_q;
   assign wr_strb = w_hs ? WSTRB : wstrb_q;

   assign slv_regs = {reg_file[3], reg_file[2], reg_file[1], reg_file[0]};

   // Build the post-write register value from the incoming data and (optionally) strobes.
   always_comb begin
      // NOTE: assign a default before any conditional update so no latch is inferred.
      wr_merged = wr_data;
`ifdef TRAFFICGENR_WSTRB_EN
      for (int i = 0; i < SW; i++) begin
         if (!wr_strb[i]) wr_merged[8*i +: 8] = reg_file[wr_idx][8*i +: 8];
      end
`endif
   end

   // Write channel: capture AW/W, commit to the register file, and drive BVALID.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         awaddr_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         BVALID   <= 1'b0;
         // NOTE: the register file is reset because software expects zeroed controls after reset.
         for (int i = 0; i < 4; i++) reg_file[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments so the read path samples pre-write register values.
         if (aw_hs) begin
            aw_held  <= 1'b1;
            awaddr_q <= AWADDR[3:2];
         end
         if (w_hs) begin
            w_held  <= 1'b1;
            wdata_q <= WDATA;
            wstrb_q <= WSTRB;
         end
         if (commit) begin
            reg_file[wr_idx] <= wr_merged;
            aw_held          <= 1'b0;
            w_held           <= 1'b0;
            BVALID           <= 1'b1;
         end else if (BVALID && BREADY) begin
            BVALID <= 1'b0;
         end
      end
   end

   // Read channel: load RDATA on the AR handshake and hold it until RREADY.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         RVALID <= 1'b0;
         RDATA  <= '0;
      end else if (ar_hs) begin
         RVALID <= 1'b1;
         RDATA  <= reg_file[ARADDR[3:2]];
      end else if (RVALID && RREADY) begin
         RVALID <= 1'b0;
         RDATA  <= '0;
      end
   end

   // Protection bits and the byte offset within a word carry no meaning for this register map.
   logic unused_bits;
   assign unused_bits = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0], wr_strb};

endmodule

// File: tb/tb_trafficgenr_axil_slave.sv
// tb_trafficgenr_axil_slave: self-checking bench for trafficgenr_axil_slave.
// Compiled with or without TRAFFICGENR_WSTRB_EN, matching the RTL build.
module tb_trafficgenr_axil_slave;

   logic         ACLK = 1'b0;
   logic         ARESETN;
   logic [3:0]   AWADDR;
   logic [2:0]   AWPROT;
   logic         AWVALID;
   logic         AWREADY;
   logic [31:0]  WDATA;
   logic [3:0]   WSTRB;
   logic         WVALID;
   logic         WREADY;
   logic [1:0]   BRESP;
   logic         BVALID;
   logic         BREADY;
   logic [3:0]   ARADDR;
   logic [2:0]   ARPROT;
   logic         ARVALID;
   logic         ARREADY;
   logic [31:0]  RDATA;
   logic [1:0]   RRESP;
   logic         RVALID;
   logic         RREADY;
   logic [127:0] slv_regs;

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model: the four registers as software sees them.
   logic [31:0] m_regs [4];

   trafficgenr_axil_slave dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
      .slv_regs(slv_regs)
   );

   always #5 ACLK = ~ACLK;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] model_slv();
      return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
   endfunction

   // Register update rule: strobed bytes only when strobes are enabled, else the whole word.
   task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
      logic [31:0] nv;
      nv = data;
`ifdef TRAFFICGENR_WSTRB_EN
      for (int b = 0; b < 4; b++) if (!strb[b]) nv[8*b +: 8] = m_regs[addr[3:2]][8*b +: 8];
`else
      strb = strb;
`endif
      m_regs[addr[3:2]] = nv;
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   // Hold BREADY low for 'hold' cycles (response must persist, channels blocked), then complete B.
   task automatic finish_b(input int hold);
      for (int c = 0; c < hold; c++) begin
         tick();
         check("b_hold_valid", BVALID, 1'b1);
         check("b_hold_ready", {AWREADY, WREADY}, 2'b00);
      end
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
      check("b_done", {BVALID, AWREADY, WREADY}, 3'b011);
   endtask

   // AW and W presented together: BVALID and the register update appear one edge later.
   task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int hold);
      AWADDR = addr; AWVALID = 1'b1;
      WDATA = data; WSTRB = strb; WVALID = 1'b1;
      check("wr_ready", {AWREADY, WREADY}, 2'b11);
      tick();
      AWVALID = 1'b0; WVALID = 1'b0;
      model_write(addr, data, strb);
      check("wr_bvalid", BVALID, 1'b1);
      check("wr_bresp", BRESP, 2'b00);
      check("wr_regs", slv_regs, model_slv());
      finish_b(hold);
   endtask

   // One channel first, the other 'gap' cycles later; commit lands on the second handshake.
   task automatic do_write_split(input logic [3:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input int gap, input bit w_first);
      if (w_first) begin
         WDATA = data; WSTRB = strb; WVALID = 1'b1;
      end else begin
         AWADDR = addr; AWVALID = 1'b1;
      end
      tick();
      AWVALID = 1'b0; WVALID = 1'b0;
      for (int c = 0; c < gap; c++) begin
         check("split_wait_b", BVALID, 1'b0);
         check("split_wait_ready", {AWREADY, WREADY}, w_first ? 2'b10 : 2'b01);
         check("split_wait_regs", slv_regs, model_slv());
         if (c < gap - 1) tick();
      end
      if (w_first) begin
         AWADDR = addr; AWVALID = 1'b1;
      end else begin
         WDATA = data; WSTRB = strb; WVALID = 1'b1;
      end
      tick();
      AWVALID = 1'b0; WVALID = 1'b0;
      model_write(addr, data, strb);
      check("split_bvalid", BVALID, 1'b1);
      check("split_regs", slv_regs, model_slv());
      finish_b(0);
   endtask

   // AR handshake; RDATA must match the model and stay stable while RREADY is low.
   task automatic do_read(input logic [3:0] addr, input int hold);
      logic [31:0] exp;
      exp = m_regs[addr[3:2]];
      ARADDR = addr; ARVALID = 1'b1;
      check("rd_arready", ARREADY, 1'b1);
      tick();
      ARVALID = 1'b0;
      check("rd_valid", {RVALID, ARREADY}, 2'b10);
      check("rd_data", RDATA, exp);
      check("rd_resp", RRESP, 2'b00);
      for (int c = 0; c < hold; c++) begin
         tick();
         check("rd_hold", {RVALID, RDATA}, {1'b1, exp});
      end
      RREADY = 1'b1;
      tick();
      RREADY = 1'b0;
      check("rd_done", {RVALID, ARREADY, RDATA}, {2'b01, 32'h0});
   endtask

   initial begin
      logic [31:0] exp_strobe;
      ARESETN = 1'b1;
      AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
      WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
      ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
      for (int i = 0; i < 4; i++) m_regs[i] = '0;

      // Reset values
      #2 ARESETN = 1'b0;
      #5;
      check("rst_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
      check("rst_valid", {BVALID, RVALID, BRESP, RRESP}, 6'b0);
      check("rst_rdata", RDATA, 32'h0);
      check("rst_regs", slv_regs, 128'h0);
      #15 ARESETN = 1'b1;
      tick();

      // Sequential words
      for (int i = 0; i < 4; i++) do_write(4'(i * 4), 32'(i + 1), 4'hF, 0);
      for (int i = 0; i < 4; i++) do_read(4'(i * 4), 0);
      check("seq_regs", slv_regs, 128'h00000004_00000003_00000002_00000001);

      // Channel ordering: W three cycles before AW, then AW first
      do_write_split(4'h8, 32'hDEADBEEF, 4'hF, 3, 1'b1);
      check("order_w_first", slv_regs[95:64], 32'hDEADBEEF);
      do_write_split(4'h8, 32'hCAFEF00D, 4'hF, 3, 1'b0);
      check("order_aw_first", slv_regs[95:64], 32'hCAFEF00D);

      // Response back-pressure on B and R
      do_write(4'h4, 32'h0BADF00D, 4'hF, 5);
      do_write(4'hC, 32'h12345678, 4'hF, 0);
      do_read(4'h4, 5);

      // Back-to-back reads with RREADY held high: one read every two cycles
      ARADDR = 4'hC; ARVALID = 1'b1; RREADY = 1'b1;
      for (int c = 0; c < 6; c++) begin
         check("b2b_arready", ARREADY, (c % 2 == 0));
         tick();
         check("b2b_rvalid", RVALID, (c % 2 == 0));
         if (c % 2 == 0) check("b2b_rdata", RDATA, 32'h12345678);
      end
      ARVALID = 1'b0; RREADY = 1'b0;

      // Strobes
      do_write(4'h4, 32'h11223344, 4'hF, 0);
      do_write(4'h4, 32'hAABBCCDD, 4'b0101, 0);
`ifdef TRAFFICGENR_WSTRB_EN
      exp_strobe = 32'h11BB33DD;
`else
      exp_strobe = 32'hAABBCCDD;
`endif
      check("strobe_0101", slv_regs[63:32], exp_strobe);
      do_write(4'h4, 32'h55555555, 4'b0000, 0);
      do_read(4'h4, 0);

      // Unaligned addresses are aligned down
      do_write(4'h7, 32'h7777AAAA, 4'hF, 0);
      do_read(4'h5, 0);

      // Collision: read and commit to reg0 on the same edge returns the old value
      do_write(4'h0, 32'h5, 4'hF, 0);
      ARADDR = 4'h0; ARVALID = 1'b1;
      AWADDR = 4'h0; AWVALID = 1'b1; WDATA = 32'h9; WSTRB = 4'hF; WVALID = 1'b1;
      tick();
      ARVALID = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
      check("coll_rdata", {RVALID, RDATA}, {1'b1, 32'h5});
      check("coll_commit", {BVALID, slv_regs[31:0]}, {1'b1, 32'h9});
      model_write(4'h0, 32'h9, 4'hF);
      RREADY = 1'b1; BREADY = 1'b1;
      tick();
      RREADY = 1'b0; BREADY = 1'b0;
      check("coll_idle", {RVALID, BVALID}, 2'b00);
      do_read(4'h0, 0);

      // Randomised traffic against the model
      for (int n = 0; n < 60; n++) begin
         logic [3:0]  ra;
         logic [31:0] rd;
         logic [3:0]  rs;
         ra = 4'($urandom_range(0, 15));
         rd = $urandom;
         rs = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 2))
            0: do_write(ra, rd, rs, $urandom_range(0, 3));
            1: do_write_split(ra, rd, rs, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
            default: do_read(ra, $urandom_range(0, 3));
         endcase
      end
      check("rand_regs", slv_regs, model_slv());

      // Reset mid-operation: held AW discarded, later lone W must not commit
      AWADDR = 4'h4; AWVALID = 1'b1;
      tick();
      AWVALID = 1'b0;
      check("mid_aw_held", {AWREADY, WREADY, BVALID}, 3'b010);
      #2 ARESETN = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) m_regs[i] = '0;
      check("mid_rst_ready", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'b11100);
      check("mid_rst_regs", slv_regs, 128'h0);
      #10 ARESETN = 1'b1;
      tick();
      WDATA = 32'hFFFF0000; WSTRB = 4'hF; WVALID = 1'b1;
      tick();
      WVALID = 1'b0;
      for (int c = 0; c < 4; c++) begin
         check("mid_w_alone", {BVALID, AWREADY, WREADY}, 3'b010);
         check("mid_w_regs", slv_regs, model_slv());
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/trafficgenr_axil_slave.md
# trafficgenr_axil_slave

AXI4-Lite responder for the trafficgenr IP: the S00_AXI register slave that the bench master VIP drives. It holds four 32-bit control registers, accepts address and data on independent channels in any order, and returns write and read responses with back-pressure. The register contents are exported to the traffic-generator core.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32: data width. Only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: byte address width. Covers 4 word registers.

Ports:
- ACLK  in  1  single clock; all logic is rising-edge.
- ARESETN  in  1  asynchronous, active-low reset.
- AWADDR  in  4  write address. Bits [3:2] select the register; bits [1:0] are ignored.
- AWPROT  in  3  accepted and ignored.
- AWVALID / AWREADY  in / out  1  write-address handshake.
- WDATA  in  32  write data.
- WSTRB  in  4  byte strobes.
- WVALID / WREADY  in / out  1  write-data handshake.
- BRESP  out  2  write response; always 2'b00 (OKAY).
- BVALID / BREADY  out / in  1  write-response handshake.
- ARADDR  in  4  read address. Bits [3:2] select the register.
- ARPROT  in  3  accepted and ignored.
- ARVALID / ARREADY  in / out  1  read-address handshake.
- RDATA  out  32  read data.
- RRESP  out  2  read response; always 2'b00.
- RVALID / RREADY  out / in  1  read-data handshake.
- slv_regs  out  128  concatenation {reg3, reg2, reg1, reg0}, driven directly from the registers.

## Operation
- State elements:
  - Four registers reg0..reg3.
  - Write-side flags aw_held and w_held, with captured awaddr_q and wdata_q/wstrb_q.
  - Output registers for BVALID, RVALID and RDATA.
- Write-channel readiness: AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID. Both are combinational from registered state only.
- Write handshake: an AW handshake sets aw_held and captures the address; a W handshake sets w_held and captures data and strobes. The two may occur in either order or in the same cycle.
- Write commit: happens on the first edge at which both are present (held, or handshaking that cycle) and BVALID = 0. On that edge:
  - the register selected by bits [3:2] is updated;
  - aw_held and w_held are cleared;
  - BVALID is set.
- BVALID stays high until BREADY is sampled high; it clears on that edge. No new AW or W is accepted while BVALID is high.
- Read side: ARREADY = !RVALID. On an AR handshake edge, RDATA is loaded from the selected register and RVALID is set. RVALID and RDATA hold until RREADY is high, and clear on that edge.
- Read and write channels are fully independent. At most one outstanding write and one outstanding read.

## Timing
- Reset values (immediate on ARESETN low, asynchronous):
  - AWREADY = 1, WREADY = 1, ARREADY = 1.
  - BVALID = 0, RVALID = 0, RDATA = 0, BRESP = 0, RRESP = 0.
  - reg0..reg3 = 0, so slv_regs = 0; aw_held = 0, w_held = 0.
- Write latency: AW and W handshaking in cycle N gives the register updated and BVALID = 1 after edge N. This is the minimum latency.
- If W arrives k cycles after AW, the commit occurs on the W handshake edge.
- Read latency: an AR handshake in cycle N gives RVALID = 1 with data after edge N.
- Back-to-back reads: with RREADY held high, ARREADY is low for 1 cycle per read, giving a maximum of one read every 2 cycles.
- Same-edge read and commit to the same register: RDATA returns the pre-write value. The next read returns the new value.
- Reset mid-transaction: held address/data and pending B/R responses are discarded; no partial register update occurs.
- Unmapped address bits [1:0] ≠ 0: the access is word-aligned down, still responds OKAY.

## Configuration
- TRAFFICGENR_WSTRB_EN defined: only bytes with WSTRB[i] = 1 update byte i of the target register. WSTRB = 4'b0000 completes with OKAY and leaves the register unchanged.
- TRAFFICGENR_WSTRB_EN undefined: WSTRB is ignored and every committed write replaces all 32 bits.

## Test plan
- Sequential words: after reset, write 0x1, 0x2, 0x3, 0x4 to addresses 0x0/0x4/0x8/0xC, each with AW and W in the same cycle. Read each back → 0x1..0x4 with RRESP = 0; slv_regs = 0x00000004_00000003_00000002_00000001. Each BVALID comes exactly 1 cycle after its handshake.
- Channel ordering: drive W(0xDEADBEEF) 3 cycles before AW(0x8) → single commit on the AW edge; reg2 = 0xDEADBEEF. Repeat with AW first → same result, with WREADY low only while BVALID is pending.
- Response back-pressure: hold BREADY = 0 for 5 cycles after a write → BVALID stays 1, AWREADY = WREADY = 0 throughout. A second write is accepted only after the B handshake. Same check for RREADY, with RDATA held stable.
- Strobes (TRAFFICGENR_WSTRB_EN defined): with reg1 = 0x11223344, write 0xAABBCCDD with WSTRB = 4'b0101 → reg1 = 0x11BB33DD. With the macro undefined, the same write gives 0xAABBCCDD.
- Collision: with reg0 = 0x5, an AR to 0x0 and a write commit of 0x9 to 0x0 on the same edge → RDATA = 0x5. The following read returns 0x9.
- Reset mid-operation: AW to 0x4 held with no W, then pulse ARESETN low → all READY = 1, BVALID = 0, all registers 0. A later W alone produces no commit.
